// File: rtl/tape_pkg.sv
// Shared types and helpers for the cassette playback engine.
package tape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_SYNC,
    ST_DATA,
    ST_PAUSE,
    ST_DONE
  } tape_state_e;

  localparam int unsigned TAP_INDEX_DEFAULT = 1;

  function automatic int unsigned half_period(input logic bit_val,
                                              input int unsigned zero_half,
                                              input int unsigned one_half);
    return bit_val ? one_half : zero_half;
  endfunction

endpackage

// File: rtl/tape_bit_timer.sv
// One bit-cell generator: ear high for H cycles, then low for H cycles.
module tape_bit_timer #(
  parameter int unsigned TW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          load,
  input  logic          hold,
  input  logic [TW-1:0] half,
  output logic          ear,
  output logic          busy,
  output logic          cell_done
);

  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] half_q, half_d;
  logic          ear_q, ear_d;
  logic          busy_q, busy_d;

  assign ear       = ear_q;
  assign busy      = busy_q;
  // Fires in the final low cycle so a load in that cycle keeps cells gap-free.
  assign cell_done = busy_q && !ear_q && (cnt_q == '0) && !hold;

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    ear_d  = ear_q;
    busy_d = busy_q;
    if (clear) begin
      cnt_d  = '0;
      ear_d  = 1'b0;
      busy_d = 1'b0;
    end else if (load) begin
      half_d = half;
      cnt_d  = half - TW'(1);
      ear_d  = 1'b1;
      busy_d = 1'b1;
    end else if (busy_q && !hold) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - TW'(1);
      end else if (ear_q) begin
        ear_d = 1'b0;
        cnt_d = half_q - TW'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      half_q <= '0;
      ear_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      ear_q  <= ear_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/tape_player.sv
// Cassette playback: captures TAP length, fetches bytes from tape RAM and
// serialises them (leader, sync, data MSB first) into the EAR square wave.
module tape_player
  import tape_pkg::*;
#(
  parameter int unsigned TAP_INDEX   = TAP_INDEX_DEFAULT,
  parameter int unsigned ZERO_HALF   = 7000,
  parameter int unsigned ONE_HALF    = 14000,
  parameter int unsigned LEADER_BITS = 768,
  parameter int unsigned AW          = 20
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic          play,
  input  logic          stop,
  input  logic          rewind,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_ack,
  input  logic [7:0]    rd_data,
  output logic          ear,
  output logic          active,
  output logic [AW-1:0] tape_len
);

  localparam int unsigned MAXH = (ONE_HALF > ZERO_HALF) ? ONE_HALF : ZERO_HALF;
  localparam int unsigned TW   = $clog2(MAXH + 1);
  localparam int unsigned LW   = (LEADER_BITS > 1) ? $clog2(LEADER_BITS) : 1;

  tape_state_e   state_q, state_d, ret_q, ret_d, nxt;
  logic [AW-1:0] pos_q, pos_d, len_q, len_d, addr_q, addr_d;
  logic [LW-1:0] lead_q, lead_d;
  logic [7:0]    shift_q, shift_d, buf_q, buf_d;
  logic [2:0]    bit_q, bit_d;
  logic          buf_vld_q, buf_vld_d;
  logic          req_q, req_d, pend_q, pend_d, disc_q, disc_d, dl_q, dl_d;

  logic          dl_tap, kill, ack_now, store_now, byte_avail, is_active;
  logic [7:0]    byte_nxt;
  logic          load_byte, fetch_new, cell_end;
  logic          tmr_load, tmr_bit, tmr_ear, tmr_busy, tmr_done;
  logic [TW-1:0] tmr_half;
  logic          unused_addr;

  assign unused_addr = ^ioctl_addr[24:AW];

  assign dl_tap     = ioctl_download && (ioctl_index == 8'(TAP_INDEX));
  assign kill       = rewind || (dl_tap && !dl_q);
  assign ack_now    = rd_ack && req_q;
  assign store_now  = ack_now && !disc_q && !kill;
  // An ack arriving in the cycle the shifter needs a byte is bypassed straight in.
  assign byte_avail = buf_vld_q || store_now;
  assign byte_nxt   = buf_vld_q ? buf_q : rd_data;
  assign is_active  = (state_q == ST_LEADER) || (state_q == ST_SYNC) || (state_q == ST_DATA);
  // Timer idle in SYNC/DATA means an underrun: the cell waits, ear low.
  assign cell_end   = tmr_done || !tmr_busy;
  assign tmr_half   = TW'(half_period(tmr_bit, ZERO_HALF, ONE_HALF));

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    pos_d     = pos_q;
    len_d     = len_q;
    addr_d    = addr_q;
    lead_d    = lead_q;
    shift_d   = shift_q;
    buf_d     = buf_q;
    bit_d     = bit_q;
    buf_vld_d = buf_vld_q;
    req_d     = req_q;
    pend_d    = pend_q;
    disc_d    = disc_q;
    dl_d      = dl_tap;
    nxt       = state_q;
    load_byte = 1'b0;
    fetch_new = 1'b0;
    tmr_load  = 1'b0;
    tmr_bit   = 1'b0;

    if (dl_tap && ioctl_wr) len_d = ioctl_addr[AW-1:0] + AW'(1);

    if (ack_now) begin
      req_d  = 1'b0;
      disc_d = 1'b0;
    end
    if (store_now) begin
      buf_d     = rd_data;
      buf_vld_d = 1'b1;
    end

    if (kill) begin
      state_d   = ST_IDLE;
      pos_d     = '0;
      buf_vld_d = 1'b0;
      pend_d    = 1'b0;
      disc_d    = req_q && !ack_now;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (play && !stop && !dl_tap && (len_q != '0)) begin
            nxt      = ST_LEADER;
            pos_d    = '0;
            lead_d   = LW'(LEADER_BITS - 1);
            tmr_load = 1'b1;
          end
        end
        ST_LEADER: begin
          if (tmr_done) begin
            tmr_load = 1'b1;
            if (lead_q == '0) begin
              nxt       = ST_SYNC;
              tmr_bit   = 1'b1;
              fetch_new = 1'b1;
            end else begin
              lead_d = lead_q - LW'(1);
            end
          end
        end
        ST_SYNC: begin
          if (cell_end && byte_avail) begin
            nxt       = ST_DATA;
            load_byte = 1'b1;
          end
        end
        ST_DATA: begin
          if (cell_end) begin
            if (bit_q != 3'd0) begin
              bit_d    = bit_q - 3'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              tmr_load = 1'b1;
              tmr_bit  = shift_q[6];
            end else if (pos_q == len_q) begin
              nxt = ST_DONE;
            end else if (byte_avail) begin
              load_byte = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (play && !stop) nxt = ret_q;
        end
        default: nxt = ST_IDLE;
      endcase

      if (load_byte) begin
        shift_d   = byte_nxt;
        bit_d     = 3'd7;
        buf_vld_d = 1'b0;
        pos_d     = pos_q + AW'(1);
        tmr_load  = 1'b1;
        tmr_bit   = byte_nxt[7];
        fetch_new = ((pos_q + AW'(1)) != len_q);
      end

      // Work due in the stop cycle still completes; PAUSE resumes into its target.
      if (stop && is_active &&
          ((nxt == ST_LEADER) || (nxt == ST_SYNC) || (nxt == ST_DATA))) begin
        state_d = ST_PAUSE;
        ret_d   = nxt;
      end else begin
        state_d = nxt;
      end

      if (fetch_new || pend_q) begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pos_d;
          pend_d = 1'b0;
        end else begin
          pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      pos_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      lead_q    <= '0;
      shift_q   <= '0;
      buf_q     <= '0;
      bit_q     <= '0;
      buf_vld_q <= 1'b0;
      req_q     <= 1'b0;
      pend_q    <= 1'b0;
      disc_q    <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      pos_q     <= pos_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      lead_q    <= lead_d;
      shift_q   <= shift_d;
      buf_q     <= buf_d;
      bit_q     <= bit_d;
      buf_vld_q <= buf_vld_d;
      req_q     <= req_d;
      pend_q    <= pend_d;
      disc_q    <= disc_d;
      dl_q      <= dl_d;
    end
  end

  tape_bit_timer #(.TW(TW)) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (kill),
    .load      (tmr_load),
    .hold      (state_q == ST_PAUSE),
    .half      (tmr_half),
    .ear       (tmr_ear),
    .busy      (tmr_busy),
    .cell_done (tmr_done)
  );

  assign rd_req   = req_q;
  assign rd_addr  = addr_q;
  assign ear      = tmr_ear;
  assign active   = is_active;
  assign tape_len = len_q;

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player with a small tape RAM model.
module tb_tape_player;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        play, stop, rewind;
  logic        rd_req, rd_ack;
  logic [19:0] rd_addr, tape_len;
  logic [7:0]  rd_data;
  logic        ear, active;

  int checks = 0;
  int failures = 0;
  int ram_lat = 3;
  int lat_cnt = 0;
  logic spur_ack = 1'b0;
  int req_drop_cnt = 0;
  logic prev_req = 1'b0;
  logic ack_seen;
  logic [7:0] mem [0:3];

  always #5 clk = ~clk;

  tape_player #(.ZERO_HALF(4), .ONE_HALF(8), .LEADER_BITS(2)) dut (
    .clock(clk), .reset_n(rst_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .play(play), .stop(stop), .rewind(rewind),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .ear(ear), .active(active), .tape_len(tape_len)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM model: acks ram_lat cycles after rd_req, data valid with the ack.
  initial begin
    rd_ack = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_ack) rd_ack = 1'b0;
      else if (spur_ack) begin
        rd_ack = 1'b1; rd_data = 8'h00; spur_ack = 1'b0;
      end else if (rd_req) begin
        lat_cnt++;
        if (lat_cnt >= ram_lat) begin
          rd_ack = 1'b1; rd_data = mem[rd_addr[1:0]]; lat_cnt = 0;
        end
      end else lat_cnt = 0;
    end
  end

  // rd_req may only fall in the cycle after an accepted ack.
  initial begin
    forever begin
      @(posedge clk);
      ack_seen = rd_ack;
      #1;
      if (rst_n && prev_req && !rd_req && !ack_seen) req_drop_cnt++;
      prev_req = rst_n ? rd_req : 1'b0;
    end
  end

  function automatic int hh(input logic b);
    return b ? 8 : 4;
  endfunction

  task automatic run_len(input logic lvl, input int cap, output int n);
    n = 0;
    while (ear === lvl && n < cap) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_cell(input string tag, input logic b, input logic last);
    int n;
    run_len(1'b1, 40, n);
    check_eq({tag, "_hi"}, n, hh(b));
    if (last) begin
      run_len(1'b0, 30, n);
      check_eq({tag, "_lo_final"}, n, 30);
    end else begin
      run_len(1'b0, 40, n);
      check_eq({tag, "_lo"}, n, hh(b));
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] v, input int from_bit,
                            input logic last);
    for (int i = from_bit; i >= 0; i--)
      check_cell($sformatf("%s_b%0d", tag, i), v[i], last && (i == 0));
  endtask

  task automatic pulse_play();
    play = 1'b1; @(negedge clk); play = 1'b0;
  endtask

  task automatic download(input logic [7:0] idx, input int n, input logic tap, input int base);
    ioctl_download = 1'b1;
    ioctl_index = idx;
    for (int i = 0; i < n; i++) begin
      ioctl_addr = 25'(i);
      ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      check_eq("dl_len", tape_len, tap ? i + 1 : base);
      @(negedge clk);
    end
    ioctl_download = 1'b0;
    @(negedge clk);
  endtask

  task automatic leader_sync(input string tag);
    check_cell({tag, "_ld0"}, 1'b0, 1'b0);
    check_cell({tag, "_ld1"}, 1'b0, 1'b0);
    check_cell({tag, "_sync"}, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h00;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0; ioctl_addr = '0;
    play = 1'b0; stop = 1'b0; rewind = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_ear", ear, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_rd_req", rd_req, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_tape_len", tape_len, 0);

    pulse_play();
    @(negedge clk);
    check_eq("empty_play_active", active, 0);

    download(8'd1, 3, 1'b1, 0);
    check_eq("len_after_tap", tape_len, 3);
    download(8'd2, 5, 1'b0, 3);
    check_eq("len_after_other", tape_len, 3);

    // Uninterrupted stream
    pulse_play();
    check_eq("play_active", active, 1);
    leader_sync("run");
    check_byte("run_a5", 8'hA5, 7, 1'b0);
    check_byte("run_00", 8'h00, 7, 1'b0);
    check_byte("run_ff", 8'hFF, 7, 1'b1);
    check_eq("done_active", active, 0);
    check_eq("done_ear", ear, 0);

    // Slow RAM: sync low stretches until byte 0 arrives
    ram_lat = 40;
    pulse_play();
    check_cell("ur_ld0", 1'b0, 1'b0);
    check_cell("ur_ld1", 1'b0, 1'b0);
    run_len(1'b1, 40, n);
    check_eq("ur_sync_hi", n, 8);
    run_len(1'b0, 100, n);
    check_eq("ur_sync_lo_long", n > 8, 1);
    check_byte("ur_a5", 8'hA5, 7, 1'b0);
    check_byte("ur_00", 8'h00, 7, 1'b0);
    check_byte("ur_ff", 8'hFF, 7, 1'b1);
    check_eq("ur_req_no_drop", req_drop_cnt, 0);
    ram_lat = 3;

    // Pause in the first data high half (bit 7 of 0xA5 = '1')
    pulse_play();
    leader_sync("pz");
    check_eq("pz_pre_hi0", ear, 1);
    @(negedge clk);
    check_eq("pz_pre_hi1", ear, 1);
    @(negedge clk);
    check_eq("pz_pre_hi2", ear, 1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pz_hold_ear", ear, 1);
    check_eq("pz_active", active, 0);
    pulse_play();
    run_len(1'b1, 40, n);
    check_eq("pz_rem_hi", n, 5);
    run_len(1'b0, 40, n);
    check_eq("pz_b7_lo", n, 8);
    check_byte("pz_a5", 8'hA5, 6, 1'b0);
    check_byte("pz_00", 8'h00, 7, 1'b0);
    check_byte("pz_ff", 8'hFF, 7, 1'b1);

    // Rewind with the byte-1 prefetch outstanding
    pulse_play();
    leader_sync("rw");
    check_eq("rw_req_out", rd_req, 1);
    rewind = 1'b1; @(negedge clk); rewind = 1'b0;
    check_eq("rw_req_held", rd_req, 1);
    check_eq("rw_active", active, 0);
    check_eq("rw_ear", ear, 0);
    n = 0;
    while (rd_req && n < 20) begin n++; @(negedge clk); end
    check_eq("rw_ack_absorbed", rd_req, 0);
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("spur_no_req", rd_req, 0);
    check_eq("rw_idle_ear", ear, 0);
    pulse_play();
    leader_sync("rw2");
    check_byte("rw2_a5", 8'hA5, 7, 1'b0);

    // Asynchronous reset in the middle of a cell
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ear", ear, 0);
    check_eq("arst_active", active, 0);
    check_eq("arst_rd_req", rd_req, 0);
    check_eq("arst_tape_len", tape_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("req_no_drop", req_drop_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
